conv_0_div_div_24cud: RTL and testbench

CONV_0_DIV_DIV_24CUD -- requirements
Module: conv_0_div_div_24cud

---
 rtl/conv_0_div_div_24cud.sv | 148 ++++++++++++++
 tb/tb_conv_0_div_div_24cud.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv_0_div_div_24cud.sv
// conv_0_div_div_24cud: iterative signed divider, restoring algorithm, one quotient bit per enabled cycle.
// Define CONV_0_DIV_SAT_EN to saturate out-of-range quotients (and flag overflow); otherwise they wrap.
module conv_0_div_div_24cud #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 24,
  parameter int          din1_WIDTH = 8,
  parameter int          dout_WIDTH = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         busy,
  output logic                         done,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH-1:0] remd,
  output logic                         div_by_zero,
  output logic                         overflow
);
  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam int QW = din0_WIDTH + 1;
  localparam int RW = din1_WIDTH + 1;

  localparam logic signed [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [QW-1:0] mag0_p0;
  logic [RW-1:0] mag1_p0;
  logic          sign0_p0, sign1_p0;
  logic [QW-1:0] quo_p0;
  logic [RW-1:0] rem_p0;
  logic [CW-1:0] cnt_p0;

  logic [RW:0]   trial;
  logic [RW-1:0] diff;
  logic          ge;
  logic signed [QW-1:0] q_true;
  logic signed [RW-1:0] r_true;

  function automatic logic [QW-1:0] abs0(input logic signed [din0_WIDTH-1:0] v);
    logic signed [QW-1:0] x;
    x = v;
    return x[QW-1] ? -x : x;
  endfunction

  function automatic logic [RW-1:0] abs1(input logic signed [din1_WIDTH-1:0] v);
    logic signed [RW-1:0] x;
    x = v;
    return x[RW-1] ? -x : x;
  endfunction

`ifdef CONV_0_DIV_SAT_EN
  localparam logic signed [QW-1:0] QMAX = QW'(DMAX);
  localparam logic signed [QW-1:0] QMIN = QW'(DMIN);

  function automatic logic q_ovf(input logic signed [QW-1:0] q);
    return (q > QMAX) || (q < QMIN);
  endfunction

  function automatic logic signed [dout_WIDTH-1:0] q_fit(input logic signed [QW-1:0] q);
    if (q > QMAX) return DMAX;
    if (q < QMIN) return DMIN;
    return dout_WIDTH'(q);
  endfunction
`else
  function automatic logic signed [dout_WIDTH-1:0] q_fit(input logic signed [QW-1:0] q);
    return dout_WIDTH'(q);
  endfunction
`endif

  // Partial remainder never reaches 2*divisor, so the low RW bits of the difference are exact.
  assign trial  = {rem_p0, mag0_p0[din0_WIDTH-1]};
  assign ge     = trial >= {1'b0, mag1_p0};
  assign diff   = trial[RW-1:0] - mag1_p0;
  assign q_true = (sign0_p0 ^ sign1_p0) ? -$signed(quo_p0) : $signed(quo_p0);
  assign r_true = sign0_p0 ? -$signed(rem_p0) : $signed(rem_p0);

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge ap_clk) begin
    if (ap_rst)  state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt_p0 == CW'(din0_WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operand capture on acceptance, then one restoring step per enabled CALC cycle
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      if (state == IDLE && start) begin
        mag0_p0  <= abs0(din0);
        mag1_p0  <= abs1(din1);
        sign0_p0 <= din0[din0_WIDTH-1];
        sign1_p0 <= din1[din1_WIDTH-1];
        quo_p0   <= '0;
        rem_p0   <= '0;
        cnt_p0   <= '0;
      end else if (state == CALC) begin
        mag0_p0 <= mag0_p0 << 1;
        quo_p0  <= {quo_p0[din0_WIDTH-1:0], ge};
        rem_p0  <= ge ? diff : trial[RW-1:0];
        cnt_p0  <= cnt_p0 + CW'(1);
      end
    end
  end

  // p1: sign fix-up and range handling into the held result registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout        <= '0;
      remd        <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (ce && state == FIX) begin
      if (mag1_p0 == '0) begin
        dout        <= sign0_p0 ? DMIN : DMAX;
        remd        <= '0;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end else begin
        dout        <= q_fit(q_true);
        remd        <= din1_WIDTH'(r_true);
        div_by_zero <= 1'b0;
`ifdef CONV_0_DIV_SAT_EN
        overflow    <= q_ovf(q_true);
`else
        overflow    <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv_0_div_div_24cud.sv
// Self-checking bench for conv_0_div_div_24cud: directed corner cases plus random operands
// against an integer-arithmetic reference; honours CONV_0_DIV_SAT_EN if defined.
module tb_conv_0_div_div_24cud;
  logic               ap_clk = 1'b0;
  logic               ap_rst, ce, start;
  logic signed [23:0] din0;
  logic signed [7:0]  din1;
  logic               busy, done;
  logic signed [15:0] dout;
  logic signed [7:0]  remd;
  logic               div_by_zero, overflow;

  int checks = 0;
  int errs   = 0;

  always #5 ap_clk = ~ap_clk;

  conv_0_div_div_24cud dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ce          (ce),
    .start       (start),
    .din0        (din0),
    .din1        (din1),
    .busy        (busy),
    .done        (done),
    .dout        (dout),
    .remd        (remd),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: truncating integer division, remainder follows dividend.
  task automatic model(input int d0, input int d1, output longint eq, output longint er,
                       output longint ez, output longint eo);
    longint q;
    if (d1 == 0) begin
      eq = (d0 >= 0) ? 32767 : -32768;
      er = 0; ez = 1; eo = 0;
    end else begin
      q  = longint'(d0) / longint'(d1);
      er = longint'(d0) % longint'(d1);
      ez = 0;
`ifdef CONV_0_DIV_SAT_EN
      if (q > 32767)       begin eq = 32767;  eo = 1; end
      else if (q < -32768) begin eq = -32768; eo = 1; end
      else                 begin eq = q;      eo = 0; end
`else
      eq = longint'($signed(q[15:0]));
      eo = 0;
`endif
    end
  endtask

  task automatic run_div(input int d0, input int d1, input int stall_at, input int stall_len,
                         input bit pulse, input string tag);
    longint eq, er, ez, eo;
    int n, busy_bad, extra_done;
    bit got;
    model(d0, d1, eq, er, ez, eo);
    @(negedge ap_clk);
    ce = 1'b1; start = 1'b1; din0 = d0[23:0]; din1 = d1[7:0];
    @(posedge ap_clk); #1;
    start = 1'b0;
    n = 1; got = 1'b0; busy_bad = 0;
    while (!got && n < 200) begin
      @(negedge ap_clk);
      ce = !(n >= stall_at && n < stall_at + stall_len);
      if (pulse && n == 6) begin
        start = 1'b1; din0 = 24'($urandom); din1 = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge ap_clk); #1;
      n++;
      if (done) got = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
    end
    ce = 1'b1; start = 1'b0;
    check_val({tag, " done_seen"}, longint'(got), 1);
    check_val({tag, " latency"}, n, 26 + stall_len);
    check_val({tag, " busy_between"}, busy_bad, 0);
    check_val({tag, " dout"}, longint'(dout), eq);
    check_val({tag, " remd"}, longint'(remd), er);
    check_val({tag, " div_by_zero"}, longint'(div_by_zero), ez);
    check_val({tag, " overflow"}, longint'(overflow), eo);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge ap_clk); #1;
      if (done || busy) extra_done++;
    end
    check_val({tag, " single_done"}, extra_done, 0);
    check_val({tag, " dout_hold"}, longint'(dout), eq);
  endtask

  initial begin
    int d0, d1, t, dones;
    logic [23:0] rv;
    ap_rst = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_val("rst busy", longint'(busy), 0);
    check_val("rst done", longint'(done), 0);
    check_val("rst dout", longint'(dout), 0);
    check_val("rst remd", longint'(remd), 0);
    check_val("rst flags", longint'({div_by_zero, overflow}), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    run_div(1000, 7, 0, 0, 1'b0, "p1000_d7");
    run_div(-1000, 7, 0, 0, 1'b0, "n1000_d7");
    run_div(1000, -7, 0, 0, 1'b0, "p1000_dn7");
    run_div(8388607, 1, 0, 0, 1'b0, "max_d1");
    run_div(-8388608, -1, 0, 0, 1'b0, "min_dn1");
    run_div(-8388608, -128, 0, 0, 1'b0, "min_dn128");
    run_div(-8388608, 127, 0, 0, 1'b0, "min_d127");
    run_div(5, 0, 0, 0, 1'b0, "p5_d0");
    run_div(-5, 0, 0, 0, 1'b0, "n5_d0");
    run_div(0, -3, 0, 0, 1'b0, "zero_dn3");
    run_div(1000, 7, 10, 5, 1'b1, "stall_pulse");

    // Reset 10 cycles into CALC with ce low and start high: reset wins, no done follows.
    @(negedge ap_clk);
    din0 = 24'sd1000; din1 = 8'sd7; start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1; ce = 1'b0; start = 1'b1;
    @(posedge ap_clk); #1;
    check_val("abort busy", longint'(busy), 0);
    check_val("abort done", longint'(done), 0);
    check_val("abort dout", longint'(dout), 0);
    check_val("abort remd", longint'(remd), 0);
    check_val("abort flags", longint'({div_by_zero, overflow}), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0; ce = 1'b1; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk); #1;
      if (done || busy) dones++;
    end
    check_val("abort no_done", dones, 0);
    run_div(-12345, 13, 0, 0, 1'b0, "after_abort");

    for (int k = 0; k < 30; k++) begin
      rv = 24'($urandom);
      t  = int'($signed(rv));
      d0 = t >>> $urandom_range(0, 23);
      d1 = int'($urandom_range(0, 255)) - 128;
      run_div(d0, d1, (k % 3 == 0) ? int'($urandom_range(2, 24)) : 0,
              (k % 3 == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
